// File: rtl/fib_pkg.sv
// Shared Fibonacci (Zeckendorf) code definitions: bit j weighs F(j+2).
package fib_pkg;

   localparam int FIB_W = 20;
   localparam logic [FIB_W-1:0] FIB_MAX = 20'hAAAAA;

   function automatic logic fib_canonical(input logic [FIB_W-1:0] code);
      return (code & (code >> 1)) == '0;
   endfunction

endpackage

// File: rtl/fib20.sv
// Combinational Zeckendorf incrementer; the maximum code rolls over to 0.
module fib20
   import fib_pkg::*;
(
   input  logic [FIB_W-1:0] count_i,
   output logic [FIB_W-1:0] count_o
);

   logic [FIB_W:0]   w_code_ext;
   logic [FIB_W:0]   w_work;
   logic [FIB_W+1:0] w_pend;

   // A pending one at j either merges with a one at j+1 into j+2, or settles at j.
   always_comb begin
      w_code_ext = {1'b0, count_i};
      w_work     = {1'b0, count_i};
      w_pend     = '0;
      if (count_i[0]) begin
         w_work[0] = 1'b0;
         w_pend[1] = 1'b1;
      end else begin
         w_pend[0] = 1'b1;
      end
      for (int j = 0; j < FIB_W; j++) begin
         if (w_pend[j]) begin
            if (w_code_ext[j+1]) begin
               w_work[j+1] = 1'b0;
               w_pend[j+2] = 1'b1;
            end else begin
               w_work[j] = 1'b1;
            end
         end
      end
      count_o = w_work[FIB_W-1:0];
   end

endmodule

// File: rtl/fib_inc_arbiter.sv
// Round-robin sharing of one fib20 incrementer: stage A grants and latches, stage B increments.
module fib_inc_arbiter
   import fib_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_BITS = 2
) (
   input  logic                     clock_i,
   input  logic                     reset_ni,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*FIB_W-1:0] count_i,
   output logic [NUM_REQ-1:0]       ack_o,
   output logic                     valid_o,
   output logic [ID_BITS-1:0]       id_o,
   output logic [FIB_W-1:0]         count_o,
   output logic                     wrap_o,
   output logic                     err_o
);

   logic [NUM_REQ-1:0] w_elig;
   logic               w_win_found;
   logic [ID_BITS-1:0] w_win_id;
   logic [ID_BITS-1:0] w_ptr_nxt;
   logic [FIB_W-1:0]   w_win_code;
   logic [FIB_W-1:0]   w_inc_code;

   logic               r_a_valid;
   logic [ID_BITS-1:0] r_a_id;
   logic [FIB_W-1:0]   r_a_code;
   logic [ID_BITS-1:0] r_ptr;

   logic [NUM_REQ-1:0] r_ack;
   logic               r_valid;
   logic [ID_BITS-1:0] r_id;
   logic [FIB_W-1:0]   r_count;
   logic               r_wrap;
   logic               r_err;

   // The requester sitting in stage A is masked so it cannot be granted twice before its ack.
   always_comb begin
      w_elig = req_i;
      if (r_a_valid) w_elig[r_a_id] = 1'b0;
      w_win_found = 1'b0;
      w_win_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_win_found && w_elig[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_win_found = 1'b1;
            w_win_id    = ID_BITS'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
   end

   assign w_win_code = count_i[int'(w_win_id)*FIB_W +: FIB_W];
   assign w_ptr_nxt  = (int'(w_win_id) == NUM_REQ - 1) ? '0 : w_win_id + 1'b1;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_a_valid <= 1'b0;
         r_a_id    <= '0;
         r_a_code  <= '0;
         r_ptr     <= '0;
      end else begin
         r_a_valid <= w_win_found;
         if (w_win_found) begin
            r_a_id   <= w_win_id;
            r_a_code <= w_win_code;
            r_ptr    <= w_ptr_nxt;
         end
      end
   end

   fib20 u_fib20 (
      .count_i (r_a_code),
      .count_o (w_inc_code)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_ack   <= '0;
         r_valid <= 1'b0;
         r_id    <= '0;
         r_count <= '0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end else if (r_a_valid) begin
         r_valid <= 1'b1;
         r_id    <= r_a_id;
         r_ack   <= NUM_REQ'(1) << r_a_id;
         if (!fib_canonical(r_a_code)) begin
            r_err   <= 1'b1;
            r_wrap  <= 1'b0;
            r_count <= r_a_code;
         end else if (r_a_code == FIB_MAX) begin
            r_err   <= 1'b0;
            r_wrap  <= 1'b1;
            r_count <= '0;
         end else begin
            r_err   <= 1'b0;
            r_wrap  <= 1'b0;
            r_count <= w_inc_code;
         end
      end else begin
         // Idle: strobes drop, count/id keep the last result.
         r_ack   <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end
   end

   assign ack_o   = r_ack;
   assign valid_o = r_valid;
   assign id_o    = r_id;
   assign count_o = r_count;
   assign wrap_o  = r_wrap;
   assign err_o   = r_err;

endmodule

// File: tb/tb_fib_inc_arbiter.sv
// Bench for fib_inc_arbiter: arithmetic reference model, result scoreboard, requester models.
module tb_fib_inc_arbiter;

   logic        clk;
   logic        reset_ni;
   logic [3:0]  req_v;
   logic [79:0] count_v;
   logic [3:0]  ack;
   logic        valid;
   logic [1:0]  id;
   logic [19:0] cnt_out;
   logic        wrap;
   logic        err;

   logic [19:0] reg_cnt [4];
   logic [3:0]  once_m;
   logic [23:0] exp_q [$];
   int          ack_log [$];

   int          n_checks = 0;
   int          n_err    = 0;
   int          n_acks   = 0;
   int          n_wraps  = 0;
   int          sweep_step = 0;
   logic        sweep_on = 1'b0;

   logic        m_av;
   logic [1:0]  m_aid;
   logic [19:0] m_acode;
   int          m_ptr;

   assign count_v = {reg_cnt[3], reg_cnt[2], reg_cnt[1], reg_cnt[0]};

   fib_inc_arbiter #(.NUM_REQ(4), .ID_BITS(2)) dut (
      .clock_i  (clk),
      .reset_ni (reset_ni),
      .req_i    (req_v),
      .count_i  (count_v),
      .ack_o    (ack),
      .valid_o  (valid),
      .id_o     (id),
      .count_o  (cnt_out),
      .wrap_o   (wrap),
      .err_o    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int fib_weight(input int j);
      int a, b, t;
      a = 1;
      b = 2;
      for (int k = 0; k < j; k++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int fib_decode(input logic [19:0] c);
      int s = 0;
      for (int j = 0; j < 20; j++) if (c[j]) s += fib_weight(j);
      return s;
   endfunction

   function automatic logic [19:0] fib_encode(input int v);
      logic [19:0] c = '0;
      for (int j = 19; j >= 0; j--) begin
         if (fib_weight(j) <= v) begin
            c[j] = 1'b1;
            v -= fib_weight(j);
         end
      end
      return c;
   endfunction

   // Packed result: {id[1:0], wrap, err, count[19:0]}.
   function automatic logic [23:0] exp_result(input logic [1:0] rid, input logic [19:0] code);
      int v;
      if ((code & (code >> 1)) != 20'h0) return {rid, 1'b0, 1'b1, code};
      v = fib_decode(code);
      if (v == 17710) return {rid, 1'b1, 1'b0, 20'h0};
      return {rid, 1'b0, 1'b0, fib_encode(v + 1)};
   endfunction

   task automatic model_edge();
      logic [3:0] elig;
      int win;
      if (!reset_ni) begin
         m_ptr = 0;
         m_av  = 1'b0;
         exp_q.delete();
         return;
      end
      if (m_av) exp_q.push_back(exp_result(m_aid, m_acode));
      elig = req_v;
      if (m_av) elig[m_aid] = 1'b0;
      win = -1;
      for (int k = 0; k < 4; k++) begin
         if (win < 0 && elig[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      end
      if (win >= 0) begin
         m_av    = 1'b1;
         m_aid   = 2'(win);
         m_acode = reg_cnt[win];
         m_ptr   = (win + 1) % 4;
      end else begin
         m_av = 1'b0;
      end
   endtask

   task automatic check_outputs();
      logic [23:0] e;
      int rid;
      if (!reset_ni) begin
         check("rst_valid", valid, 0);
         check("rst_ack", ack, 0);
         check("rst_id", id, 0);
         check("rst_count", cnt_out, 0);
         check("rst_wrap", wrap, 0);
         check("rst_err", err, 0);
         return;
      end
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         rid = int'(e[23:22]);
         check("valid", valid, 1);
         check("ack", ack, 32'(4'b0001 << rid));
         check("id", id, rid);
         check("count", cnt_out, e[19:0]);
         check("wrap", wrap, e[21]);
         check("err", err, e[20]);
         reg_cnt[rid] = e[19:0];
         ack_log.push_back(rid);
         n_acks++;
         if (once_m[rid]) req_v[rid] = 1'b0;
         if (sweep_on) begin
            sweep_step++;
            check("sweep_val", fib_decode(cnt_out), sweep_step % 17711);
            if (e[21]) n_wraps++;
         end
      end else begin
         check("idle_valid", valid, 0);
         check("idle_ack", ack, 0);
         check("idle_wrap", wrap, 0);
         check("idle_err", err, 0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_acks(input string tag, input int n, input int budget);
      int target;
      target = n_acks + n;
      for (int i = 0; i < budget && n_acks < target; i++) tick();
      if (n_acks < target) check(tag, n_acks, target);
   endtask

   task automatic do_reset();
      reset_ni = 1'b0;
      req_v    = '0;
      idle(2);
      reset_ni = 1'b1;
   endtask

   initial begin
      reset_ni = 1'b0;
      req_v    = '0;
      once_m   = '0;
      m_av     = 1'b0;
      m_aid    = '0;
      m_acode  = '0;
      m_ptr    = 0;
      for (int i = 0; i < 4; i++) reg_cnt[i] = '0;
      idle(3);
      reset_ni = 1'b1;
      idle(1);

      // Single requester counting, acked every other cycle.
      once_m = 4'b0000;
      req_v  = 4'b0001;
      wait_acks("p1_timeout", 5, 30);
      req_v = '0;
      check("p1_final", reg_cnt[0], 20'h00008);
      idle(3);

      // All four requesters from reset: strict round-robin order.
      do_reset();
      for (int i = 0; i < 4; i++) reg_cnt[i] = '0;
      ack_log.delete();
      req_v = 4'b1111;
      wait_acks("p2_timeout", 8, 30);
      req_v = '0;
      for (int i = 0; i < 8; i++) check("p2_order", ack_log[i], i % 4);
      idle(3);

      // Wrap from the maximum code, then a non-canonical code.
      once_m = 4'b1111;
      reg_cnt[2] = 20'hAAAAA;
      req_v = 4'b0100;
      wait_acks("p3_timeout", 1, 10);
      check("p3_wrapcnt", reg_cnt[2], 20'h00000);
      idle(2);
      reg_cnt[1] = 20'h00003;
      req_v = 4'b0010;
      wait_acks("p4_timeout", 1, 10);
      check("p4_errcnt", reg_cnt[1], 20'h00003);
      idle(2);

      // Request dropped while held in stage A still completes.
      reg_cnt[3] = 20'h00005;
      req_v = 4'b1000;
      tick();
      req_v = '0;
      wait_acks("p5_timeout", 1, 10);
      check("p5_dropcnt", reg_cnt[3], 20'h00008);
      idle(2);

      // Reset right after a grant discards it; then lowest requesting index wins.
      ack_log.delete();
      req_v = 4'b0011;
      tick();
      reset_ni = 1'b0;
      req_v = '0;
      idle(2);
      reset_ni = 1'b1;
      idle(2);
      check("p6_no_ack", ack_log.size(), 0);
      reg_cnt[1] = 20'h00001;
      reg_cnt[3] = 20'h00004;
      req_v = 4'b1010;
      wait_acks("p6_timeout", 2, 10);
      check("p6_first", ack_log[0], 1);
      check("p6_second", ack_log[1], 3);
      idle(2);

      // Full sweep of one counter through the wrap.
      once_m = 4'b0000;
      reg_cnt[0] = '0;
      sweep_step = 0;
      n_wraps = 0;
      sweep_on = 1'b1;
      req_v = 4'b0001;
      wait_acks("p7_timeout", 17711, 40000);
      req_v = '0;
      sweep_on = 1'b0;
      idle(3);
      check("p7_wraps", n_wraps, 1);
      check("p7_final", reg_cnt[0], 20'h00000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
